ps2_rx_fifo: RTL and testbench

//  PS/2 device-to-host receiver feeding the keyboard scan-code decoder. Synchronises the raw
//  ps2_clk/ps2_data pins, deserialises 11-bit frames (start, 8 data LSB-first, odd parity,

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_byte_fifo.sv | 60 ++++++
 rtl/ps2_rx_fifo.sv | 128 ++++++++++++
 tb/tb_ps2_rx_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame geometry, receiver states
// and the parity rule applied to each received byte.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic {
        IDLE,
        RECV
    } ps2_state_t;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead byte FIFO with occupancy count and sticky overflow flag.
// Head byte is a combinational read of the registered array.
module ps2_byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  push,
    input  logic [7:0]            wdata,
    input  logic                  pop,
    output logic [7:0]            rdata,
    output logic                  ready,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_cnt;
    logic [DEPTH_LOG2:0] rd_cnt;
    logic                full;
    logic                empty;
    logic                do_pop;
    logic                do_push;

    assign level   = wr_cnt - rd_cnt;
    assign empty   = (level == '0);
    assign full    = (level == FULL_LEVEL);
    assign ready   = ~empty;
    assign rdata   = mem[rd_cnt[DEPTH_LOG2-1:0]];
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_cnt[DEPTH_LOG2-1:0]] <= wdata;
                wr_cnt <= wr_cnt + CNT_ONE;
            end
            if (do_pop) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end
            if (push && full && !do_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, frame deserialiser with
// parity/stop validation and mid-frame timeout, feeding a show-ahead byte FIFO.
module ps2_rx_fifo #(
    parameter int unsigned DEPTH_LOG2     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  nextdata_n,
    output logic [7:0]            data,
    output logic                  ready,
    output logic                  overflow,
    output logic                  frame_err,
    output logic [DEPTH_LOG2:0]   level
);

    import ps2_pkg::*;

    localparam int unsigned       TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        STOP_IDX = 4'(FRAME_BITS - 1);

    logic            clk_meta, clk_sync, clk_prev;
    logic            data_meta, data_sync;
    logic            fall;
    ps2_state_t      state, state_nx;
    logic [3:0]      bit_cnt;
    logic [8:0]      shift;
    logic [TO_W-1:0] to_cnt;
    logic            push;
    logic            bad;

    assign fall = clk_prev & ~clk_sync;

    // Idle bus level is high, so synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        bad      = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !data_sync) begin
                    state_nx = RECV;
                end
            end
            RECV: begin
                if (fall) begin
                    if (bit_cnt == STOP_IDX) begin
                        state_nx = IDLE;
                        if (data_sync && odd_parity_ok(shift[7:0], shift[8])) begin
                            push = 1'b1;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                end else if (to_cnt == TO_LAST) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // After nine shifts shift[7:0] holds the byte LSB-first and shift[8] the parity bit.
    always_ff @(posedge clk) begin
        if (clr) begin
            bit_cnt   <= '0;
            shift     <= '0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad;
            if (state == IDLE) begin
                to_cnt <= '0;
                if (fall && !data_sync) begin
                    bit_cnt <= 4'd1;
                end
            end else if (fall) begin
                to_cnt  <= '0;
                shift   <= {data_sync, shift[8:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    ps2_byte_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .clr      (clr),
        .push     (push),
        .wdata    (shift[7:0]),
        .pop      (~nextdata_n),
        .rdata    (data),
        .ready    (ready),
        .overflow (overflow),
        .level    (level)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed PS/2 frames, a queue-based FIFO model checked
// every cycle, and literal expectations for each scenario.
module tb_ps2_rx_fifo;

    localparam int unsigned DEPTH_LOG2 = 3;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned TIMEOUT    = 200;
    localparam int unsigned HALF       = 8;

    logic       clk = 1'b0;
    logic       clr;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;
    logic [3:0] level;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DEPTH_LOG2    (DEPTH_LOG2),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err),
        .level     (level)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int err_pulses;

    // Frame events posted by the stimulus, consumed by the model
    int         ev_seq = 0;
    int         ev_seen = 0;
    logic [7:0] ev_byte;
    logic       ev_good;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_err = 1'b0;

    // Model: a byte becomes visible on the third clk edge after the stop-bit fall on the pin
    always @(posedge clk) begin
        bit pop_ok;
        if (clr) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_err   = 1'b0;
            ev_seen = ev_seq;
        end else begin
            m_err  = 1'b0;
            pop_ok = !nextdata_n && (mq.size() > 0);
            if (pop_ok) void'(mq.pop_front());
            if (ev_seen != ev_seq) begin
                ev_seen = ev_seq;
                if (ev_good) begin
                    if (mq.size() < DEPTH) mq.push_back(ev_byte);
                    else m_ovf = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic flip, input logic stop);
        return {stop, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [10:0] f, input int nbits, input bit pop_with_push);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                @(posedge clk);
                @(posedge clk);
                #1;
                ev_byte = f[8:1];
                ev_good = (^f[9:1]) && f[10];
                ev_seq++;
                if (pop_with_push) nextdata_n = 1'b0;
                @(posedge clk);
                #1;
                nextdata_n = 1'b1;
            end
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(make_frame(b, 1'b0, 1'b1), 11, 1'b0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        @(negedge clk);
        check(name, 32'(data), 32'(exp));
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    initial begin
        clr        = 1'b1;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        err_pulses = 0;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 'h00);
        check("rst_ready", 32'(ready), 0);
        check("rst_level", 32'(level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        clr = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (frame_err) err_pulses++;
                check("cyc_ready", 32'(ready), 32'(mq.size() != 0));
                check("cyc_level", 32'(level), 32'(mq.size()));
                check("cyc_overflow", 32'(overflow), 32'(m_ovf));
                check("cyc_frame_err", 32'(frame_err), 32'(m_err));
                if (mq.size() != 0) check("cyc_data", 32'(data), 32'(mq[0]));
            end
        join_none

        // 1: single good frame
        send_byte(8'h1C);
        @(negedge clk);
        check("t1_ready", 32'(ready), 1);
        check("t1_level", 32'(level), 1);
        check("t1_errs", 32'(err_pulses), 0);
        pop_check("t1_data", 8'h1C);

        // 2: parity error
        err_pulses = 0;
        send_frame(make_frame(8'h1C, 1'b1, 1'b1), 11, 1'b0);
        @(negedge clk);
        check("t2_err_pulses", 32'(err_pulses), 1);
        check("t2_ready", 32'(ready), 0);
        check("t2_level", 32'(level), 0);

        // 3: overfill then drain
        for (int b = 1; b <= 9; b++) send_byte(8'(b));
        @(negedge clk);
        check("t3_level", 32'(level), 8);
        check("t3_overflow", 32'(overflow), 1);
        for (int b = 1; b <= 8; b++) pop_check("t3_pop", 8'(b));
        @(negedge clk);
        check("t3_empty", 32'(ready), 0);

        // 4: full FIFO, pop coincides with push
        pulse_clr();
        for (int b = 'h11; b <= 'h18; b++) send_byte(8'(b));
        send_frame(make_frame(8'h19, 1'b0, 1'b1), 11, 1'b1);
        @(negedge clk);
        check("t4_level", 32'(level), 8);
        check("t4_overflow", 32'(overflow), 0);
        check("t4_head", 32'(data), 'h12);

        // 5: abandoned frame times out
        pulse_clr();
        err_pulses = 0;
        send_frame(make_frame(8'hAA, 1'b0, 1'b1), 5, 1'b0);
        repeat (TIMEOUT + 2) @(negedge clk);
        send_byte(8'hF0);
        @(negedge clk);
        check("t5_level", 32'(level), 1);
        check("t5_data", 32'(data), 'hF0);
        check("t5_errs", 32'(err_pulses), 0);

        // 6: clear mid-frame with bytes pending
        pulse_clr();
        send_byte(8'h21);
        send_byte(8'h22);
        send_byte(8'h23);
        @(negedge clk);
        check("t6_level_before", 32'(level), 3);
        send_frame(make_frame(8'h5A, 1'b0, 1'b1), 4, 1'b0);
        pulse_clr();
        check("t6_ready", 32'(ready), 0);
        check("t6_level", 32'(level), 0);
        check("t6_overflow", 32'(overflow), 0);
        send_byte(8'h58);
        @(negedge clk);
        check("t6_level_after", 32'(level), 1);
        check("t6_data", 32'(data), 'h58);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
